// File: rtl/fp_align_if.sv
// fp_align_if: operand-in / aligned-pair-out handshake bus of the align stage
//   in_valid/in_ready   operand pair handshake, in_a/in_b IEEE half operands
//   out_valid/out_ready aligned pair handshake toward the adder
//   out_a/out_b         two's-complement aligned mantissas (MW bits)
//   out_exp             common exponent, out_special Inf/NaN seen
interface fp_align_if #(parameter int MW = 15);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_a;
    logic [15:0]   in_b;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_a;
    logic [MW-1:0] out_b;
    logic [4:0]    out_exp;
    logic          out_special;
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_exp, out_special
    );
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_exp, out_special
    );
endinterface

// File: rtl/fp_align_stage.sv
// fp_align_stage: aligns two half-precision operands for a ripple-carry adder
//   clk, rst  clock and synchronous active-high reset
//   bus       fp_align_if slave: operand pair in, aligned two's-complement pair,
//             common exponent and special flag out
module fp_align_stage #(
    parameter int MW     = 15,
    parameter int MAX_SH = 14
) (
    input logic       clk,
    input logic       rst,
    fp_align_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMP   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   a_r, b_r;
    logic [14:0]   m_big, m_small;
    logic          s_big, s_small, special;
    logic [4:0]    e_big, d;
    logic [MW-1:0] oa, ob;
    logic [4:0]    oe;
    logic          osp;

    logic [4:0]  xa, xb, diff, dcap, f_e;
    logic [14:0] ma, mb, sh, f_big, f_small;
    logic        a_big, is_sp, at_cmp, f_sb, f_ss, f_sp, done_nx;

    function automatic logic [MW-1:0] tc(input logic [14:0] m, input logic s);
        tc = s ? ~MW'(m) + MW'(1) : MW'(m);
    endfunction

    // subnormals use effective exponent 1 with no hidden bit
    assign xa    = (a_r[14:10] == 5'd0) ? 5'd1 : a_r[14:10];
    assign xb    = (b_r[14:10] == 5'd0) ? 5'd1 : b_r[14:10];
    assign ma    = {1'b0, |a_r[14:10], a_r[9:0], 3'b000};
    assign mb    = {1'b0, |b_r[14:10], b_r[9:0], 3'b000};
    assign a_big = xa >= xb;
    assign diff  = a_big ? xa - xb : xb - xa;
    assign dcap  = (diff > 5'(MAX_SH)) ? 5'(MAX_SH) : diff;
    assign is_sp = (&a_r[14:10]) | (&b_r[14:10]);
    // one-bit right shift, folding the bits leaving bit0 into a sticky bit0
    assign sh    = {1'b0, m_small[14:2], m_small[1] | m_small[0]};

    // values presented to the output registers: straight from the compare
    // when no shift is needed, otherwise from the final shift step
    assign at_cmp  = state == CMP;
    assign f_big   = at_cmp ? (a_big ? ma : mb) : m_big;
    assign f_small = at_cmp ? (a_big ? mb : ma) : sh;
    assign f_sb    = at_cmp ? (a_big ? a_r[15] : b_r[15]) : s_big;
    assign f_ss    = at_cmp ? (a_big ? b_r[15] : a_r[15]) : s_small;
    assign f_e     = at_cmp ? (a_big ? xa : xb) : e_big;
    assign f_sp    = at_cmp ? is_sp : special;
    assign done_nx = at_cmp ? (is_sp || dcap == 5'd0) : (state == SHIFT && d == 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            m_big   <= '0;
            m_small <= '0;
            s_big   <= 1'b0;
            s_small <= 1'b0;
            e_big   <= '0;
            d       <= '0;
            special <= 1'b0;
            oa      <= '0;
            ob      <= '0;
            oe      <= '0;
            osp     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r   <= bus.in_a;
                    b_r   <= bus.in_b;
                    state <= CMP;
                end
                CMP: begin
                    m_big   <= f_big;
                    m_small <= f_small;
                    s_big   <= f_sb;
                    s_small <= f_ss;
                    e_big   <= f_e;
                    d       <= dcap;
                    special <= is_sp;
                    state   <= done_nx ? DONE : SHIFT;
                end
                SHIFT: begin
                    m_small <= sh;
                    d       <= d - 5'd1;
                    if (done_nx) state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
            endcase
            if (done_nx) begin
                oa  <= f_sp ? '0 : tc(f_big, f_sb);
                ob  <= f_sp ? '0 : tc(f_small, f_ss);
                oe  <= f_sp ? 5'd31 : f_e;
                osp <= f_sp;
            end
        end
    end

    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.out_a       = oa;
    assign bus.out_b       = ob;
    assign bus.out_exp     = oe;
    assign bus.out_special = osp;
endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: directed and random checks of fp_align_stage against an arithmetic model
module tb_fp_align_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_align_if #(.MW(15)) bus();
    fp_align_stage #(.MW(15), .MAX_SH(14)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // IEEE-half semantics with plain integer arithmetic
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [14:0] ra, output logic [14:0] rb,
                                  output logic [4:0] re, output logic rsp, output int lat);
        int ea, eb, ma, mb, big, sml, sb, ss, d, r, va, vb;
        ea  = (a[14:10] == 0) ? 1 : int'(a[14:10]);
        eb  = (b[14:10] == 0) ? 1 : int'(b[14:10]);
        ma  = ((a[14:10] != 0) ? 1024 : 0) + int'(a[9:0]);
        mb  = ((b[14:10] != 0) ? 1024 : 0) + int'(b[9:0]);
        ma  = ma * 8;
        mb  = mb * 8;
        rsp = (a[14:10] == 31) || (b[14:10] == 31);
        if (eb > ea) begin big = mb; sml = ma; sb = b[15]; ss = a[15]; re = 5'(eb); d = eb - ea; end
        else begin big = ma; sml = mb; sb = a[15]; ss = b[15]; re = 5'(ea); d = ea - eb; end
        if (d > 14) d = 14;
        r  = (sml >> d) | (((sml % (1 << d)) != 0) ? 1 : 0);
        va = sb ? -big : big;
        vb = ss ? -r : r;
        ra = va[14:0];
        rb = vb[14:0];
        lat = 2 + d;
        if (rsp) begin ra = '0; rb = '0; re = 5'd31; lat = 2; end
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [14:0] ea, eb;
        logic [4:0]  ee;
        logic        esp;
        int          elat, lat;
        model(a, b, ea, eb, ee, esp, elat);
        @(negedge clk);
        check("rdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'h7C00;
        bus.in_b     = 16'hFFFF;
        check("busy", 32'(bus.in_ready), 32'd0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("lat", 32'(lat), 32'(elat));
        for (int i = 0; i <= hold; i++) begin
            check("out_a", 32'(bus.out_a), 32'(ea));
            check("out_b", 32'(bus.out_b), 32'(eb));
            check("out_exp", 32'(bus.out_exp), 32'(ee));
            check("special", 32'(bus.out_special), 32'(esp));
            check("valid", 32'(bus.out_valid), 32'd1);
            if (i < hold) begin
                @(posedge clk);
                #1;
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_rdy", 32'(bus.in_ready), 32'd1);
        check("post_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_a", 32'(bus.out_a), 32'd0);
        check("rst_b", 32'(bus.out_b), 32'd0);
        check("rst_exp", 32'(bus.out_exp), 32'd0);
        check("rst_sp", 32'(bus.out_special), 32'd0);

        // directed vectors with hand-derived constants
        run_op(16'h3C00, 16'h4000, 0);
        check("v1_a", 32'(bus.out_a), 32'h2000);
        check("v1_b", 32'(bus.out_b), 32'h1000);
        check("v1_e", 32'(bus.out_exp), 32'd16);
        run_op(16'h3C00, 16'hBC00, 0);
        check("v2_b", 32'(bus.out_b), 32'h6000);
        check("v2_e", 32'(bus.out_exp), 32'd15);
        run_op(16'h4C00, 16'h3C01, 0);
        check("v3_b", 32'(bus.out_b), 32'h0201);
        check("v3_e", 32'(bus.out_exp), 32'd19);
        run_op(16'h7800, 16'h3C00, 1);
        check("v4_b", 32'(bus.out_b), 32'h0001);
        check("v4_e", 32'(bus.out_exp), 32'd30);
        run_op(16'h7C00, 16'h1234, 0);
        check("v5_sp", 32'(bus.out_special), 32'd1);
        check("v5_e", 32'(bus.out_exp), 32'd31);
        run_op(16'h0000, 16'h8000, 0);
        run_op(16'h4400, 16'h8000, 0);
        run_op(16'h0123, 16'h3FFF, 0);

        // reset mid-shift: no output pulse, ready again next cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h7800;
        bus.in_b     = 16'h3C00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("shift_novalid", 32'(bus.out_valid), 32'd0);
        end
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_rdy", 32'(bus.in_ready), 32'd1);
        check("abort_b", 32'(bus.out_b), 32'd0);
        run_op(16'hC500, 16'h4100, 5);

        // reset while holding a result in DONE
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h3C00;
        bus.in_b     = 16'h4000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("done_abort_valid", 32'(bus.out_valid), 32'd0);
        check("done_abort_rdy", 32'(bus.in_ready), 32'd1);
        check("done_abort_a", 32'(bus.out_a), 32'd0);
        check("done_abort_exp", 32'(bus.out_exp), 32'd0);

        // random pairs, biased toward special, zero and subnormal corners
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra[14:0] = '0;
                1: rb[14:10] = 5'd0;
                2: rb[14:10] = 5'd31;
                3: ra[14:10] = rb[14:10];
                default: ;
            endcase
            run_op(ra, rb, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 The block SHALL have parameter MW, default 15, giving the width of the aligned two's-complement mantissa delivered to the 15-bit ripple-carry adder.
REQ-002 The block SHALL have parameter MAX_SH, default 14, giving the alignment shift cap in cycles.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block can accept an operand pair.
REQ-008 in_a  in  16  operand A, IEEE half format {sign, exp[4:0], frac[9:0]}.
REQ-009 in_b  in  16  operand B, same format as in_a.
REQ-010 out_valid  out  1  aligned pair available.
REQ-011 out_ready  in  1  downstream adder accepts the pair.
REQ-012 out_a  out  MW  larger-exponent operand, two's complement.
REQ-013 out_b  out  MW  smaller-exponent operand, aligned, two's complement.
REQ-014 out_exp  out  5  common (larger) effective exponent.
REQ-015 out_special  out  1  an input had exp==31 (Inf/NaN).

Function
REQ-016 The block SHALL use FSM states IDLE, CMP, SHIFT and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, on in_valid=1, the block SHALL capture in_a/in_b and go to CMP; otherwise it SHALL remain in IDLE.
REQ-018 Each operand SHALL be unpacked to magnitude {1'b0, hidden, frac[9:0], 3'b000} (15 bits: hidden, frac, G, R, S).
REQ-019 Unpacking rule: hidden=1 if exp!=0; if exp==0, hidden=0 and effective exponent=1.
REQ-020 CMP (1 cycle): the operand with the larger effective exponent SHALL become big; on a tie, A SHALL be big.
REQ-021 CMP: shift count SHALL be d=min(exp_big-exp_small, MAX_SH).
REQ-022 CMP exit: if either exp==31, the block SHALL set special and go to DONE; else if d==0, go to DONE; else go to SHIFT.
REQ-023 In SHIFT, each cycle SHALL apply m_small <= {1'b0, m_small[14:1]} with new bit0 = m_small[1] | m_small[0] (sticky), decrement d, and go to DONE when d reaches 0.
REQ-024 On entry to DONE, outputs SHALL be registered: out_a=big magnitude, negated (~m+1, MW bits) if big sign=1; out_b likewise with small sign; out_exp=exp_big; out_special=special.
REQ-025 If special=1, out_a and out_b SHALL be 0 and out_exp SHALL be 31.
REQ-026 DONE: out_valid=1, and outputs SHALL hold stable until out_ready=1.
REQ-027 On out_ready=1 in DONE, the next state SHALL be IDLE; no bypass, so the minimum in_ready gap is 1 cycle.
REQ-028 Latency: out_valid SHALL rise 2+d cycles after the accepting edge (d=0 gives 2 cycles; capped d gives 16 cycles).
REQ-029 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-030 A shift of a zero mantissa SHALL yield 0 with the sticky bit 0.

Reset
REQ-031 With rst=1 at a clock edge, state SHALL become IDLE and all outputs/internal registers SHALL become 0, except in_ready=1.
REQ-032 rst in any state, including mid-SHIFT or DONE awaiting out_ready, SHALL abort the operation with no output pulse; in_ready SHALL be 1 the next cycle.
REQ-033 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-034 in_a=0x3C00 (1.0), in_b=0x4000 (2.0) -> out_a=0x2000, out_b=0x1000, out_exp=16, out_special=0, out_valid 3 cycles after accept.
REQ-035 in_a=0x3C00, in_b=0xBC00 -> out_a=0x2000, out_b=0x6000, out_exp=15, out_valid 2 cycles after accept.
REQ-036 in_a=0x4C00, in_b=0x3C01 -> out_b=0x0201 (sticky set), out_a=0x2000, out_exp=19, latency 6.
REQ-037 in_a=0x7800, in_b=0x3C00 (diff 15, capped 14) -> out_b=0x0001, out_exp=30, latency 16.
REQ-038 in_a=0x7C00 (Inf) with any in_b -> out_special=1, out_a=out_b=0, out_exp=31, latency 2.
REQ-039 Assert rst during SHIFT of the REQ-037 case -> no out_valid; in_ready=1 next cycle; then hold out_ready=0 for 5 cycles in DONE on a new pair -> outputs stable throughout.
